// File: rtl/lcd_panel_model.sv
// Responder model of an 8-bit HD44780-style character LCD: instruction decode,
// 80-byte DDRAM, address counter (AC), display flags and busy timing.
module lcd_panel_model #(
    parameter int unsigned CMD_CYCLES  = 4,
    parameter int unsigned HOME_CYCLES = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_din,
    output logic [7:0] lcd_dout,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       entry_inc,
    output logic       err,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char
);

    localparam int unsigned DEPTH    = 80;
    localparam int unsigned LINE_LEN = 40;
    localparam int unsigned AW       = 7;
    localparam int unsigned DW       = 8;
    localparam int unsigned MAX_CYC  = (HOME_CYCLES > CMD_CYCLES) ? HOME_CYCLES : CMD_CYCLES;
    localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [DW-1:0] BLANK = 8'h20;

    // AC validity for the current line mode
    function automatic logic addr_valid(input logic [AW-1:0] a, input logic tl);
        logic v;
        if (tl) begin
            v = (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
        end else begin
            v = (a <= 7'h4F);
        end
        return v;
    endfunction

    // Second line starts at physical index 40; one-line mode is linear
    function automatic logic [AW-1:0] phys_idx(input logic [AW-1:0] a, input logic tl);
        logic [AW-1:0] r;
        if (tl && a[6]) begin
            r = AW'(LINE_LEN) + {1'b0, a[5:0]};
        end else begin
            r = a;
        end
        return r;
    endfunction

    // Next AC after a data access or cursor move, with line wrap
    function automatic logic [AW-1:0] addr_step(input logic [AW-1:0] a, input logic inc,
                                                input logic tl);
        logic [AW-1:0] r;
        if (!addr_valid(a, tl)) begin
            r = '0;
        end else if (inc) begin
            if (tl && (a == 7'h27)) begin
                r = 7'h40;
            end else if ((tl && (a == 7'h67)) || (!tl && (a == 7'h4F))) begin
                r = '0;
            end else begin
                r = a + AW'(1);
            end
        end else begin
            if (a == 7'h00) begin
                r = tl ? 7'h67 : 7'h4F;
            end else if (tl && (a == 7'h40)) begin
                r = 7'h27;
            end else begin
                r = a - AW'(1);
            end
        end
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic             en_q, en_d;
    logic [AW-1:0]    ac_q, ac_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             disp_q, disp_d;
    logic             cur_q, cur_d;
    logic             blink_q, blink_d;
    logic             tl_q, tl_d;
    logic             inc_q, inc_d;
    logic             err_q, err_d;
    logic             fn_dl_q, fn_dl_d;
    logic             fn_font_q, fn_font_d;

    logic [DW-1:0]    mem_q [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_idx;
    logic [DW-1:0]    mem_wdata;

    logic             commit;
    logic             cur_valid;
    logic [AW-1:0]    cur_idx;

    // Next-state, bus decode and DDRAM write port
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_idx_d = clr_idx_q;
        en_d      = lcd_en;
        ac_d      = ac_q;
        dout_d    = dout_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        tl_d      = tl_q;
        inc_d     = inc_q;
        err_d     = err_q;
        fn_dl_d   = fn_dl_q;
        fn_font_d = fn_font_q;
        mem_we    = 1'b0;
        mem_idx   = clr_idx_q;
        mem_wdata = BLANK;
        commit    = en_q & ~lcd_en;
        cur_valid = addr_valid(ac_q, tl_q);
        cur_idx   = phys_idx(ac_q, tl_q);

        case (state_q)
            ST_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    clr_idx_d = '0;
                    ac_d      = '0;
                    inc_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + AW'(1);
                end
            end
            default: ;
        endcase

        if (commit && busy_q) begin
            // Only the status read is served while busy
            if (!lcd_rs && lcd_rw) begin
                dout_d = {1'b1, ac_q};
            end else begin
                err_d = 1'b1;
            end
        end else if (commit) begin
            case ({lcd_rs, lcd_rw})
                2'b01: begin
                    dout_d = {1'b0, ac_q};
                end
                2'b11: begin
                    dout_d  = cur_valid ? mem_q[cur_idx] : '0;
                    ac_d    = addr_step(ac_q, inc_q, tl_q);
                    state_d = ST_EXEC;
                    cnt_d   = CNT_W'(CMD_CYCLES);
                end
                2'b10: begin
                    mem_we    = cur_valid;
                    mem_idx   = cur_idx;
                    mem_wdata = lcd_din;
                    ac_d      = addr_step(ac_q, inc_q, tl_q);
                    state_d   = ST_EXEC;
                    cnt_d     = CNT_W'(CMD_CYCLES);
                end
                default: begin
                    state_d = ST_EXEC;
                    cnt_d   = CNT_W'(CMD_CYCLES);
                    casez (lcd_din)
                        8'b1???????: begin
                            if (addr_valid(lcd_din[6:0], tl_q)) begin
                                ac_d = lcd_din[6:0];
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        8'b01??????: ;
                        8'b001?????: begin
                            fn_dl_d   = lcd_din[4];
                            tl_d      = lcd_din[3];
                            fn_font_d = lcd_din[2];
                        end
                        8'b0001????: begin
                            if (!lcd_din[3]) begin
                                ac_d = addr_step(ac_q, lcd_din[2], tl_q);
                            end
                        end
                        8'b00001???: begin
                            disp_d  = lcd_din[2];
                            cur_d   = lcd_din[1];
                            blink_d = lcd_din[0];
                        end
                        8'b000001??: begin
                            inc_d = lcd_din[1];
                        end
                        8'b0000001?: begin
                            ac_d  = '0;
                            cnt_d = CNT_W'(HOME_CYCLES);
                        end
                        8'b00000001: begin
                            state_d   = ST_CLEAR;
                            clr_idx_d = '0;
                        end
                        default: ;
                    endcase
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            clr_idx_q <= '0;
            en_q      <= 1'b0;
            ac_q      <= '0;
            dout_q    <= '0;
            busy_q    <= 1'b1;
            disp_q    <= 1'b0;
            cur_q     <= 1'b0;
            blink_q   <= 1'b0;
            tl_q      <= 1'b0;
            inc_q     <= 1'b1;
            err_q     <= 1'b0;
            fn_dl_q   <= 1'b1;
            fn_font_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_idx_q <= clr_idx_d;
            en_q      <= en_d;
            ac_q      <= ac_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            disp_q    <= disp_d;
            cur_q     <= cur_d;
            blink_q   <= blink_d;
            tl_q      <= tl_d;
            inc_q     <= inc_d;
            err_q     <= err_d;
            fn_dl_q   <= fn_dl_d;
            fn_font_q <= fn_font_d;
        end
    end

    // DDRAM has no reset; the post-reset clear sweep blanks it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

    // Debug port always uses the two-line view of the physical array
    assign rd_char = addr_valid(rd_addr, 1'b1) ? mem_q[phys_idx(rd_addr, 1'b1)] : '0;

    assign lcd_dout    = dout_q;
    assign busy        = busy_q;
    assign cursor_addr = ac_q;
    assign display_on  = disp_q;
    assign cursor_on   = cur_q;
    assign blink_on    = blink_q;
    assign two_line    = tl_q;
    assign entry_inc   = inc_q;
    assign err         = err_q;

endmodule

// File: tb/tb_lcd_panel_model.sv
// Bench for lcd_panel_model: directed scenarios with literal expectations plus
// randomized bus traffic checked every cycle against a linear-position model.
module tb_lcd_panel_model;

    localparam int unsigned CMD_CYC  = 4;
    localparam int unsigned HOME_CYC = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_din;
    logic [7:0] lcd_dout;
    logic       busy;
    logic [6:0] cursor_addr;
    logic       display_on;
    logic       cursor_on;
    logic       blink_on;
    logic       two_line;
    logic       entry_inc;
    logic       err;
    logic [6:0] rd_addr;
    logic [7:0] rd_char;

    lcd_panel_model #(.CMD_CYCLES(CMD_CYC), .HOME_CYCLES(HOME_CYC)) dut (
        .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_din(lcd_din), .lcd_dout(lcd_dout), .busy(busy), .cursor_addr(cursor_addr),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .two_line(two_line), .entry_inc(entry_inc), .err(err),
        .rd_addr(rd_addr), .rd_char(rd_char)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit rand_rd = 1'b0;

    // Model: the panel as 80 linear character positions
    bit [7:0] m_mem [80];
    int       m_ac;
    int       m_busy_left;
    bit       m_clearing;
    bit       m_en_prev;
    bit [7:0] m_dout;
    bit       m_disp, m_cur, m_blink, m_tl, m_inc, m_err;

    function automatic int to_pos(input int a, input bit tl);
        if (tl) begin
            if (a < 40) return a;
            if (a >= 64 && a < 104) return a - 24;
            return -1;
        end
        if (a < 80) return a;
        return -1;
    endfunction

    function automatic int to_addr(input int p, input bit tl);
        if (tl && p >= 40) return p + 24;
        return p;
    endfunction

    function automatic int advance(input int a, input bit inc, input bit tl);
        int p;
        p = to_pos(a, tl);
        if (p < 0) return 0;
        p = inc ? (p + 1) % 80 : (p + 79) % 80;
        return to_addr(p, tl);
    endfunction

    function automatic int model_rd(input int a);
        int p;
        p = to_pos(a, 1'b1);
        if (p < 0) return 0;
        return int'(m_mem[p]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        m_ac = 0; m_busy_left = 80; m_clearing = 1'b1; m_en_prev = 1'b0;
        m_dout = 8'h00; m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0;
        m_tl = 1'b0; m_inc = 1'b1; m_err = 1'b0;
    endtask

    task automatic model_step();
        bit commit, was_busy;
        int cur_ac, p;
        bit [7:0] d;
        if (rst) begin
            model_reset();
            return;
        end
        commit = m_en_prev && !lcd_en;
        m_en_prev = lcd_en;
        was_busy = (m_busy_left > 0);
        cur_ac = m_ac;
        d = lcd_din;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0 && m_clearing) begin
                m_ac = 0; m_inc = 1'b1; m_clearing = 1'b0;
            end
        end
        if (!commit) return;
        if (was_busy) begin
            if (!lcd_rs && lcd_rw) m_dout = {1'b1, 7'(cur_ac)};
            else m_err = 1'b1;
            return;
        end
        p = to_pos(m_ac, m_tl);
        if (!lcd_rs && lcd_rw) begin
            m_dout = {1'b0, 7'(m_ac)};
        end else if (lcd_rs && lcd_rw) begin
            m_dout = (p < 0) ? 8'h00 : m_mem[p];
            m_ac = advance(m_ac, m_inc, m_tl);
            m_busy_left = CMD_CYC;
        end else if (lcd_rs) begin
            if (p >= 0) m_mem[p] = d;
            m_ac = advance(m_ac, m_inc, m_tl);
            m_busy_left = CMD_CYC;
        end else begin
            m_busy_left = CMD_CYC;
            if (d[7]) begin
                if (to_pos(int'(d[6:0]), m_tl) >= 0) m_ac = int'(d[6:0]);
                else m_err = 1'b1;
            end else if (d[6]) begin
            end else if (d[5]) begin
                m_tl = d[3];
            end else if (d[4]) begin
                if (!d[3]) m_ac = advance(m_ac, d[2], m_tl);
            end else if (d[3]) begin
                m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
            end else if (d[2]) begin
                m_inc = d[1];
            end else if (d[1]) begin
                m_ac = 0;
                m_busy_left = HOME_CYC;
            end else if (d[0]) begin
                for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
                m_busy_left = 80;
                m_clearing = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("lcd_dout", lcd_dout, m_dout);
        check("busy", busy, int'(m_busy_left > 0));
        check("cursor_addr", cursor_addr, m_ac);
        check("display_on", display_on, m_disp);
        check("cursor_on", cursor_on, m_cur);
        check("blink_on", blink_on, m_blink);
        check("two_line", two_line, m_tl);
        check("entry_inc", entry_inc, m_inc);
        check("err", err, m_err);
        if (m_busy_left == 0) check("rd_char", rd_char, model_rd(rd_addr));
    endtask

    // Inputs change only right after the falling edge; model steps on the rising edge
    task automatic tick();
        if (rand_rd) rd_addr = 7'($urandom_range(0, 127));
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic bus_txn(input bit rs, input bit rw, input bit [7:0] d);
        lcd_rs = rs; lcd_rw = rw; lcd_din = d; lcd_en = 1'b1;
        tick();
        lcd_en = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) check("wait_idle_timeout", busy, 0);
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (busy && cycles < 300) begin
            tick();
            cycles++;
        end
    endtask

    task automatic peek(input string name, input bit [6:0] a, input int exp);
        rd_addr = a;
        #1;
        check(name, rd_char, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit rs, rw;
        bit [7:0] d;
        bit [7:0] word [7];
        word = '{8'h76, 8'h65, 8'h72, 8'h69, 8'h6C, 8'h6F, 8'h67};
        rst = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_din = 8'h00; rd_addr = 7'h00;

        // Power-on reset and the 80-cycle blanking sweep
        tick(); tick();
        rst = 1'b0;
        count_busy(cyc);
        check("rst_busy_cycles", cyc, 80);
        check("rst_ac", cursor_addr, 0);
        check("rst_entry_inc", entry_inc, 1);
        check("rst_dout", lcd_dout, 0);
        peek("rst_rd_00", 7'h00, 8'h20);
        peek("rst_rd_27", 7'h27, 8'h20);
        peek("rst_rd_40", 7'h40, 8'h20);
        peek("rst_rd_67", 7'h67, 8'h20);

        // Init sequence then "verilog"
        foreach (word[i]) begin end
        wait_idle(); bus_txn(0, 0, 8'h38);
        wait_idle(); bus_txn(0, 0, 8'h01);
        wait_idle(); bus_txn(0, 0, 8'h0E);
        wait_idle(); bus_txn(0, 0, 8'h06);
        wait_idle(); bus_txn(0, 0, 8'h80);
        for (int i = 0; i < 7; i++) begin
            wait_idle(); bus_txn(1, 0, word[i]);
        end
        wait_idle();
        for (int i = 0; i < 7; i++) peek("init_text", 7'(i), word[i]);
        check("init_ac", cursor_addr, 8'h07);
        check("init_two_line", two_line, 1);
        check("init_display_on", display_on, 1);
        check("init_cursor_on", cursor_on, 1);
        check("init_blink_on", blink_on, 0);
        check("init_err", err, 0);

        // Line wrap forward and backward
        bus_txn(0, 0, 8'hA7); wait_idle();
        bus_txn(1, 0, 8'h41); wait_idle();
        bus_txn(1, 0, 8'h42); wait_idle();
        peek("wrap_rd_27", 7'h27, 8'h41);
        peek("wrap_rd_40", 7'h40, 8'h42);
        check("wrap_ac_41", cursor_addr, 8'h41);
        bus_txn(0, 0, 8'h04); wait_idle();
        bus_txn(0, 0, 8'h80); wait_idle();
        bus_txn(1, 0, 8'h43); wait_idle();
        peek("wrap_rd_00", 7'h00, 8'h43);
        check("wrap_ac_67", cursor_addr, 8'h67);

        // Writes while busy are rejected; status read is served
        bus_txn(0, 0, 8'h06);
        bus_txn(1, 0, 8'h55);
        wait_idle();
        peek("busy_wr_rd_67", 7'h67, 8'h20);
        check("busy_wr_err", err, 1);
        bus_txn(0, 0, 8'h06);
        bus_txn(0, 1, 8'h00);
        check("busy_status", lcd_dout, 8'hE7);
        wait_idle();
        bus_txn(0, 1, 8'h00);
        check("idle_status", lcd_dout, 8'h67);

        // Return home timing and cursor moves
        wait_idle(); bus_txn(0, 0, 8'h92); wait_idle();
        check("home_pre_ac", cursor_addr, 8'h12);
        bus_txn(0, 0, 8'h02);
        count_busy(cyc);
        check("home_busy_cycles", cyc, HOME_CYC);
        check("home_ac", cursor_addr, 0);
        bus_txn(0, 0, 8'h14); wait_idle();
        check("shift_r_ac", cursor_addr, 1);
        bus_txn(0, 0, 8'h10); wait_idle();
        check("shift_l_ac", cursor_addr, 0);

        // Reset in the middle of a clear restarts everything
        bus_txn(0, 0, 8'h01);
        repeat (29) tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        count_busy(cyc);
        check("rst_mid_busy_cycles", cyc, 80);
        check("rst_mid_two_line", two_line, 0);
        check("rst_mid_display_on", display_on, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_dout", lcd_dout, 0);
        check("rst_mid_entry_inc", entry_inc, 1);
        peek("rst_mid_rd_00", 7'h00, 8'h20);
        peek("rst_mid_rd_27", 7'h27, 8'h20);

        // Randomized traffic, sometimes colliding with busy
        rand_rd = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0) wait_idle();
            rs = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (!rs && !rw && d == 8'h01 && $urandom_range(0, 3) != 0) d = 8'h06;
            if (!rs && !rw && $urandom_range(0, 5) == 0) d = {4'b0010, 1'($urandom_range(0, 1)), 3'b000};
            bus_txn(rs, rw, d);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
